// File: rtl/instr_assembler_pkg.sv
// Shared definitions for the prefixed-instruction assembler and the downstream
// identification logic that reuses prefix_detect.
package instr_assembler_pkg;

  localparam logic [5:0] PREFIX_OPCODE = 6'b100000;

  // Record pc is held at full width; narrower ADDR_W instances zero-extend into it.
  localparam int REC_PC_W = 64;

  typedef enum logic [1:0] {
    EMPTY,
    PREFIX,
    OUT
  } state_e;

  typedef struct packed {
    logic [63:0]         instr;
    logic [REC_PC_W-1:0] pc;
    logic                prefixed;
    logic                align_err;
    logic                seq_err;
  } record_t;

endpackage

// File: rtl/instr_assembler_prefix_detect.sv
// Combinational classifier: is this word a prefix, and does it sit in the last
// word slot of a 64-byte block (where its suffix could never follow).
module prefix_detect
  import instr_assembler_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  pc_word_idx,
  output logic        is_prefix,
  output logic        block_last
);

  assign is_prefix  = (word[5:0] == PREFIX_OPCODE);
  assign block_last = (pc_word_idx == 4'hF);

endmodule

// File: rtl/instr_assembler.sv
// Joins a prefix word with its suffix into one 64-bit record; plain words pass
// through as single-word records. One record buffer, full-throughput handshake.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_word_valid,
  input  logic [31:0]       i_word,
  input  logic [ADDR_W-1:0] i_word_pc,
  output logic              o_word_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [63:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_prefixed,
  output logic              o_align_err,
  output logic              o_seq_err,
  output logic [CNT_W-1:0]  o_prefixed_cnt
);

  state_e            state_q, state_d;
  record_t           rec_q, rec_d;
  logic [31:0]       pfx_word_q;
  logic [ADDR_W-1:0] pfx_pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_prefix, block_last;
  logic              word_acc, rec_acc;

  prefix_detect u_prefix_detect (
    .word        (i_word),
    .pc_word_idx (i_word_pc[5:2]),
    .is_prefix   (is_prefix),
    .block_last  (block_last)
  );

  // A held record must leave in the same cycle a new word arrives, so the
  // buffer never holds a record and a partial prefix at once.
  assign o_word_ready = i_rst && !i_flush && (state_q != OUT || i_ready);
  assign o_valid      = (state_q == OUT);
  assign word_acc     = i_word_valid && o_word_ready;
  assign rec_acc      = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else if (word_acc) begin
      if (state_q == PREFIX) begin
        state_d         = OUT;
        rec_d.instr     = {i_word, pfx_word_q};
        rec_d.pc        = REC_PC_W'(pfx_pc_q);
        rec_d.prefixed  = 1'b1;
        rec_d.align_err = 1'b0;
        rec_d.seq_err   = (i_word_pc != pfx_pc_q + ADDR_W'(4));
      end else if (is_prefix && !block_last) begin
        state_d = PREFIX;
      end else begin
        // A block-last prefix is emitted alone, flagged, without awaiting a suffix.
        state_d         = OUT;
        rec_d.instr     = {32'h0, i_word};
        rec_d.pc        = REC_PC_W'(i_word_pc);
        rec_d.prefixed  = is_prefix;
        rec_d.align_err = is_prefix;
        rec_d.seq_err   = 1'b0;
      end
    end else if (rec_acc) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= EMPTY;
      rec_q      <= '0;
      pfx_word_q <= '0;
      pfx_pc_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      if (word_acc && state_q != PREFIX && is_prefix) begin
        pfx_word_q <= i_word;
        pfx_pc_q   <= i_word_pc;
      end
      if (rec_acc && rec_q.prefixed && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_instr        = rec_q.instr;
  assign o_pc           = rec_q.pc[ADDR_W-1:0];
  assign o_prefixed     = rec_q.prefixed;
  assign o_align_err    = rec_q.align_err;
  assign o_seq_err      = rec_q.seq_err;
  assign o_prefixed_cnt = cnt_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed-vector bench for instr_assembler with hand-computed expectations;
// the counter is narrowed to 4 bits so saturation is reachable.
module tb_instr_assembler;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 4;

  logic              i_clk;
  logic              i_rst;
  logic              i_flush;
  logic              i_word_valid;
  logic [31:0]       i_word;
  logic [ADDR_W-1:0] i_word_pc;
  logic              o_word_ready;
  logic              o_valid;
  logic              i_ready;
  logic [63:0]       o_instr;
  logic [ADDR_W-1:0] o_pc;
  logic              o_prefixed;
  logic              o_align_err;
  logic              o_seq_err;
  logic [CNT_W-1:0]  o_prefixed_cnt;

  int   vectors     = 0;
  int   miscompares = 0;
  logic sampled_ready;

  instr_assembler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_flush        (i_flush),
    .i_word_valid   (i_word_valid),
    .i_word         (i_word),
    .i_word_pc      (i_word_pc),
    .o_word_ready   (o_word_ready),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_instr        (o_instr),
    .o_pc           (o_pc),
    .o_prefixed     (o_prefixed),
    .o_align_err    (o_align_err),
    .o_seq_err      (o_seq_err),
    .o_prefixed_cnt (o_prefixed_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, sample o_word_ready before the edge, then settle past it.
  task automatic applyStimulus(input logic valid, input logic [31:0] word,
                               input logic [63:0] pc, input logic ready, input logic flush);
    i_word_valid = valid;
    i_word       = word;
    i_word_pc    = pc;
    i_ready      = ready;
    i_flush      = flush;
    #1;
    sampled_ready = o_word_ready;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkRecord(input string tag, input logic [63:0] instr, input logic [63:0] pc,
                             input logic [63:0] prefixed, input logic [63:0] align,
                             input logic [63:0] seq);
    checkOutput({tag, "_valid"}, 64'(o_valid), 64'd1);
    checkOutput({tag, "_instr"}, o_instr, instr);
    checkOutput({tag, "_pc"}, o_pc, pc);
    checkOutput({tag, "_prefixed"}, 64'(o_prefixed), prefixed);
    checkOutput({tag, "_align"}, 64'(o_align_err), align);
    checkOutput({tag, "_seq"}, 64'(o_seq_err), seq);
  endtask

  initial begin
    int          bubbles;
    logic [31:0] pw, sw;
    logic [63:0] ppc;

    i_rst = 1'b0;
    i_flush = 1'b0;
    i_word_valid = 1'b0;
    i_word = '0;
    i_word_pc = '0;
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;

    // Reset beats flush and blocks words.
    applyStimulus(1'b1, 32'h7C0002A6, 64'h100, 1'b1, 1'b1);
    checkOutput("rst_ready_flush", 64'(sampled_ready), 64'd0);
    applyStimulus(1'b1, 32'h7C0002A6, 64'h100, 1'b1, 1'b0);
    checkOutput("rst_ready", 64'(sampled_ready), 64'd0);
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_instr", o_instr, 64'd0);
    checkOutput("rst_pc", o_pc, 64'd0);
    checkOutput("rst_prefixed", 64'(o_prefixed), 64'd0);
    checkOutput("rst_align", 64'(o_align_err), 64'd0);
    checkOutput("rst_seq", 64'(o_seq_err), 64'd0);
    checkOutput("rst_cnt", 64'(o_prefixed_cnt), 64'd0);
    i_rst = 1'b1;

    $display("[TB] plain word");
    applyStimulus(1'b1, 32'h7C0002A6, 64'h100, 1'b1, 1'b0);
    checkOutput("plain_ready", 64'(sampled_ready), 64'd1);
    checkRecord("plain", 64'h0000_0000_7C00_02A6, 64'h100, 64'd0, 64'd0, 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("plain_drain", 64'(o_valid), 64'd0);

    $display("[TB] prefix + suffix");
    applyStimulus(1'b1, 32'h04000020, 64'h200, 1'b1, 1'b0);
    checkOutput("pfx_hold_valid", 64'(o_valid), 64'd0);
    applyStimulus(1'b1, 32'h38600001, 64'h204, 1'b1, 1'b0);
    checkRecord("pair", 64'h3860_0001_0400_0020, 64'h200, 64'd1, 64'd0, 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("pair_cnt", 64'(o_prefixed_cnt), 64'd1);
    checkOutput("pair_drain", 64'(o_valid), 64'd0);

    $display("[TB] block-last prefix");
    applyStimulus(1'b1, 32'h04000020, 64'h23C, 1'b1, 1'b0);
    checkRecord("align", 64'h0000_0000_0400_0020, 64'h23C, 64'd1, 64'd1, 64'd0);
    applyStimulus(1'b1, 32'h60000000, 64'h240, 1'b1, 1'b0);
    checkRecord("after_align", 64'h0000_0000_6000_0000, 64'h240, 64'd0, 64'd0, 64'd0);
    checkOutput("align_cnt", 64'(o_prefixed_cnt), 64'd2);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("[TB] out-of-sequence suffix");
    applyStimulus(1'b1, 32'h04000020, 64'h300, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h38600001, 64'h400, 1'b1, 1'b0);
    checkRecord("seq", 64'h3860_0001_0400_0020, 64'h300, 64'd1, 64'd0, 64'd1);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("seq_cnt", 64'(o_prefixed_cnt), 64'd3);

    $display("[TB] flush drops prefix");
    applyStimulus(1'b1, 32'h04000020, 64'h480, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h38600001, 64'h484, 1'b1, 1'b1);
    checkOutput("flush_ready", 64'(sampled_ready), 64'd0);
    checkOutput("flush_valid", 64'(o_valid), 64'd0);
    applyStimulus(1'b1, 32'h7C0002A6, 64'h500, 1'b1, 1'b0);
    checkRecord("post_flush", 64'h0000_0000_7C00_02A6, 64'h500, 64'd0, 64'd0, 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("flush_cnt", 64'(o_prefixed_cnt), 64'd3);
    checkOutput("flush_drain", 64'(o_valid), 64'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h11111111, 64'h600, 1'b0, 1'b0);
    checkRecord("stall_first", 64'h0000_0000_1111_1111, 64'h600, 64'd0, 64'd0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h22222222, 64'h604, 1'b0, 1'b0);
      checkOutput("stall_ready", 64'(sampled_ready), 64'd0);
      checkRecord("stall_hold", 64'h0000_0000_1111_1111, 64'h600, 64'd0, 64'd0, 64'd0);
    end
    applyStimulus(1'b1, 32'h22222222, 64'h604, 1'b1, 1'b0);
    checkOutput("stall_release_ready", 64'(sampled_ready), 64'd1);
    checkRecord("stall_next", 64'h0000_0000_2222_2222, 64'h604, 64'd0, 64'd0, 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // A stalled prefixed record is counted once, on delivery only.
    applyStimulus(1'b1, 32'h04000020, 64'h63C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
      checkOutput("stall_pfx_cnt", 64'(o_prefixed_cnt), 64'd3);
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("stall_pfx_delivered", 64'(o_prefixed_cnt), 64'd4);
    checkOutput("stall_pfx_drain", 64'(o_valid), 64'd0);

    $display("[TB] full-rate stream of 1000 words");
    bubbles = 0;
    for (int k = 0; k < 500; k++) begin
      pw  = 32'h04000020 | (32'(k) << 8);
      sw  = 32'hA0000000 | (32'(k) << 8);
      ppc = 64'h1000 + 64'(k) * 64'd8;
      applyStimulus(1'b1, pw, ppc, 1'b1, 1'b0);
      if (!sampled_ready) bubbles++;
      applyStimulus(1'b1, sw, ppc + 64'd4, 1'b1, 1'b0);
      if (!sampled_ready) bubbles++;
      checkOutput("stream_valid", 64'(o_valid), 64'd1);
      checkOutput("stream_instr", o_instr, {sw, pw});
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("stream_bubbles", 64'(bubbles), 64'd0);
    checkOutput("stream_cnt_sat", 64'(o_prefixed_cnt), 64'd15);

    $display("[TB] reset mid-record");
    applyStimulus(1'b1, 32'h04000020, 64'h700, 1'b1, 1'b0);
    i_rst = 1'b0;
    applyStimulus(1'b1, 32'h38600001, 64'h704, 1'b1, 1'b1);
    checkOutput("midrst_ready", 64'(sampled_ready), 64'd0);
    checkOutput("midrst_valid", 64'(o_valid), 64'd0);
    checkOutput("midrst_cnt", 64'(o_prefixed_cnt), 64'd0);
    i_rst = 1'b1;
    applyStimulus(1'b1, 32'h38600001, 64'h704, 1'b1, 1'b0);
    checkRecord("midrst_after", 64'h0000_0000_3860_0001, 64'h704, 64'd0, 64'd0, 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
